// File: rtl/gpr_file_bank_if.sv
// Gpr_file_if: pipeline-to-register-file bundle with three combinational read ports
// and two clocked write ports.
interface Gpr_file_if;
    logic [4:0]  ra_sel;
    logic [4:0]  rb_sel;
    logic [4:0]  rc_sel;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rc;
    logic [4:0]  wa_sel;
    logic [4:0]  wb_sel;
    logic [31:0] wa;
    logic [31:0] wb;
    logic        wa_wr;
    logic        wb_wr;

    modport master (
        output ra_sel, rb_sel, rc_sel, wa_sel, wb_sel, wa, wb, wa_wr, wb_wr,
        input  ra, rb, rc
    );

    modport slave (
        input  ra_sel, rb_sel, rc_sel, wa_sel, wb_sel, wa, wb, wa_wr, wb_wr,
        output ra, rb, rc
    );

    modport gpr_file (
        input  ra_sel, rb_sel, rc_sel, wa_sel, wb_sel, wa, wb, wa_wr, wb_wr,
        output ra, rb, rc
    );
endinterface

// File: rtl/gpr_file_bank.sv
// 32 x 32-bit register file: three zero-latency read ports, two write ports where
// port B wins collisions, optional same-cycle write-to-read forwarding.
module gpr_file_bank #(
    parameter int BYPASS   = 1,
    parameter int NUM_REGS = 32
) (
    input  logic         clk,
    input  logic         reset,
    Gpr_file_if.gpr_file gpr
);

    localparam logic BYP = (BYPASS != 0) ? 1'b1 : 1'b0;

    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];
    logic [31:0] ra_s;
    logic [31:0] rb_s;
    logic [31:0] rc_s;

    // Forwarding priority mirrors the write collision rule: B over A over storage.
    function automatic logic [31:0] read_word(
        input logic        rst,
        input logic [4:0]  sel,
        input logic [31:0] stored,
        input logic        wa_wr,
        input logic [4:0]  wa_sel,
        input logic [31:0] wa,
        input logic        wb_wr,
        input logic [4:0]  wb_sel,
        input logic [31:0] wb
    );
        logic [31:0] word;
        if (rst) begin
            word = 32'h0;
        end else if (BYP && wb_wr && (sel == wb_sel)) begin
            word = wb;
        end else if (BYP && wa_wr && (sel == wa_sel)) begin
            word = wa;
        end else begin
            word = stored;
        end
        return word;
    endfunction

    // Next-state array: apply A first so a same-index B write overrides it.
    always_comb begin
        regs_d = regs_q;
        if (gpr.wa_wr) begin
            regs_d[gpr.wa_sel] = gpr.wa;
        end else begin
            regs_d[gpr.wa_sel] = regs_q[gpr.wa_sel];
        end
        if (gpr.wb_wr) begin
            regs_d[gpr.wb_sel] = gpr.wb;
        end else begin
            regs_d[gpr.wb_sel] = regs_d[gpr.wb_sel];
        end
    end

    // Storage array with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports, each resolved independently.
    always_comb begin
        ra_s = read_word(reset, gpr.ra_sel, regs_q[gpr.ra_sel],
                         gpr.wa_wr, gpr.wa_sel, gpr.wa, gpr.wb_wr, gpr.wb_sel, gpr.wb);
        rb_s = read_word(reset, gpr.rb_sel, regs_q[gpr.rb_sel],
                         gpr.wa_wr, gpr.wa_sel, gpr.wa, gpr.wb_wr, gpr.wb_sel, gpr.wb);
        rc_s = read_word(reset, gpr.rc_sel, regs_q[gpr.rc_sel],
                         gpr.wa_wr, gpr.wa_sel, gpr.wa, gpr.wb_wr, gpr.wb_sel, gpr.wb);
    end

    assign gpr.ra = ra_s;
    assign gpr.rb = rb_s;
    assign gpr.rc = rc_s;

endmodule

// File: tb/tb_gpr_file_bank.sv
// Bench for gpr_file_bank: one instance per BYPASS setting fed identical stimulus,
// checked against an array model of the register file.
module tb_gpr_file_bank;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    logic [31:0] model [32];

    Gpr_file_if if_byp ();
    Gpr_file_if if_nob ();

    gpr_file_bank #(.BYPASS(1), .NUM_REGS(32)) dut_byp (.clk(clk), .reset(reset), .gpr(if_byp));
    gpr_file_bank #(.BYPASS(0), .NUM_REGS(32)) dut_nob (.clk(clk), .reset(reset), .gpr(if_nob));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] ras, input logic [4:0] rbs, input logic [4:0] rcs,
                         input logic awr, input logic [4:0] as_, input logic [31:0] ad,
                         input logic bwr, input logic [4:0] bs, input logic [31:0] bd);
        if_byp.ra_sel = ras; if_nob.ra_sel = ras;
        if_byp.rb_sel = rbs; if_nob.rb_sel = rbs;
        if_byp.rc_sel = rcs; if_nob.rc_sel = rcs;
        if_byp.wa_wr = awr;  if_nob.wa_wr = awr;
        if_byp.wa_sel = as_; if_nob.wa_sel = as_;
        if_byp.wa = ad;      if_nob.wa = ad;
        if_byp.wb_wr = bwr;  if_nob.wb_wr = bwr;
        if_byp.wb_sel = bs;  if_nob.wb_sel = bs;
        if_byp.wb = bd;      if_nob.wb = bd;
    endtask

    // Expected read value straight from the port rules.
    function automatic logic [31:0] expect_rd(input logic [4:0] sel, input bit byp);
        if (reset) return 32'h0;
        if (byp && if_byp.wb_wr && sel == if_byp.wb_sel) return if_byp.wb;
        if (byp && if_byp.wa_wr && sel == if_byp.wa_sel) return if_byp.wa;
        return model[sel];
    endfunction

    task automatic check_all(input string tag);
        #1;
        chk({tag, "_ra_byp"}, if_byp.ra, expect_rd(if_byp.ra_sel, 1'b1));
        chk({tag, "_rb_byp"}, if_byp.rb, expect_rd(if_byp.rb_sel, 1'b1));
        chk({tag, "_rc_byp"}, if_byp.rc, expect_rd(if_byp.rc_sel, 1'b1));
        chk({tag, "_ra_nob"}, if_nob.ra, expect_rd(if_nob.ra_sel, 1'b0));
        chk({tag, "_rb_nob"}, if_nob.rb, expect_rd(if_nob.rb_sel, 1'b0));
        chk({tag, "_rc_nob"}, if_nob.rc, expect_rd(if_nob.rc_sel, 1'b0));
    endtask

    // Advance one clock, updating the model with what the edge sampled.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else begin
            if (if_byp.wa_wr) model[if_byp.wa_sel] = if_byp.wa;
            if (if_byp.wb_wr) model[if_byp.wb_sel] = if_byp.wb;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [4:0]  s_a, s_b;
        logic [31:0] d_a, d_b;
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        reset = 1'b1;
        drive(5'd1, 5'd2, 5'd3, 1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222);
        @(negedge clk);
        tick();
        check_all("reset_hold");
        chk("reset_hold_const", if_byp.ra, 32'h0);
        reset = 1'b0;

        // Fill every entry with nonzero data, A on even and B on odd indices.
        for (int i = 0; i < 32; i += 2) begin
            drive(5'(i), 5'(i + 1), 5'd0, 1'b1, 5'(i), 32'hA000_0000 | 32'(i + 1),
                  1'b1, 5'(i + 1), 32'hB000_0000 | 32'(i + 2));
            check_all("fill");
            tick();
        end
        drive(5'd4, 5'd9, 5'd31, 1'b1, 5'd4, 32'h7777_7777, 1'b1, 5'd9, 32'h9999_9999);
        check_all("filled");
        // Asynchronous reset mid-cycle, with live writes that must not forward.
        #2;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        check_all("async_reset");
        chk("async_reset_rc_const", if_nob.rc, 32'h0);
        tick();
        reset = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i += 3) begin
            drive(5'(i), 5'((i + 1) % 32), 5'((i + 2) % 32), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
            check_all("post_reset_zero");
            chk("post_reset_ra_const", if_nob.ra, 32'h0);
        end

        // Basic dual write, then read back.
        drive(5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd31, 32'h1234_5678);
        tick();
        drive(5'd5, 5'd31, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_all("basic");
        chk("basic_ra_const", if_nob.ra, 32'hDEAD_BEEF);
        chk("basic_rb_const", if_nob.rb, 32'h1234_5678);
        chk("basic_rc_const", if_nob.rc, 32'h0);

        // Collision: B wins, and forwards B in the same cycle.
        drive(5'd7, 5'd7, 5'd7, 1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
        check_all("collide_same");
        chk("collide_fwd_const", if_byp.ra, 32'h2);
        tick();
        drive(5'd7, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_all("collide_next");
        chk("collide_store_const", if_nob.ra, 32'h2);

        // Forwarding versus stored value.
        drive(5'd0, 5'd0, 5'd3, 1'b1, 5'd3, 32'hAAAA_0000, 1'b0, 5'd0, 32'h0);
        tick();
        drive(5'd0, 5'd0, 5'd3, 1'b1, 5'd3, 32'h5555_FFFF, 1'b0, 5'd0, 32'h0);
        check_all("bypass_same");
        chk("bypass_on_const", if_byp.rc, 32'h5555_FFFF);
        chk("bypass_off_const", if_nob.rc, 32'hAAAA_0000);
        tick();
        drive(5'd0, 5'd0, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_all("bypass_next");
        chk("bypass_next_const", if_nob.rc, 32'h5555_FFFF);

        // r0 is an ordinary register.
        drive(5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_all("r0");
        chk("r0_const", if_nob.ra, 32'hFFFF_FFFF);

        // Random regression, reads biased toward the active write indices.
        for (int c = 0; c < 10000; c++) begin
            s_a = 5'($urandom_range(0, 31));
            s_b = ($urandom_range(0, 3) == 0) ? s_a : 5'($urandom_range(0, 31));
            d_a = $urandom;
            d_b = $urandom;
            drive(($urandom_range(0, 1) == 1) ? s_a : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 1) == 1) ? s_b : 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), s_a, d_a,
                  1'($urandom_range(0, 1)), s_b, d_b);
            reset = ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
            if (reset) begin
                for (int i = 0; i < 32; i++) model[i] = 32'h0;
            end
            check_all("rand");
            tick();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
